fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async FWFT FIFO among NUM_REQ requesters in the wr_clk domain.
- Packet-aware round-robin: once a grant is issued, it is held until that requester's last beat.
- Guarantees fifo_wr_en_o is never asserted while fifo_wr_full_i is high. The FIFO memory write enable is not gated by full internally, so this gating is mandatory here.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- DATA_WIDTH, 8, beat width; equals the FIFO_WIDTH of the attached FIFO.
- PACKET_MODE, 1, 1: hold grant until req_last_i; 0: every beat is treated as last.
- TIMEOUT_CYCLES, 256, idle-stall limit; used only with FIFO_WR_ARB_TIMEOUT_EN.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_reset_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed beats; requester k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  last beat of packet.
- req_ready_o  out  NUM_REQ  beat accepted when valid&ready.
- fifo_wr_data_o  out  DATA_WIDTH  to FIFO wr_data_i.
- fifo_wr_en_o  out  1  to FIFO wr_en_i.
- fifo_wr_full_i  in  1  from FIFO wr_full_o.
- grant_o  out  NUM_REQ  one-hot current owner; 0 when none.
- busy_o  out  1  high in LOCK.
- timeout_o  out  1  present only with FIFO_WR_ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, synchronous release on wr_clk):
  - State IDLE, rr_ptr=0, grant_o=0.
  - req_ready_o=0, fifo_wr_en_o=0, fifo_wr_data_o=0, busy_o=0, timeout_o=0.
- FSM IDLE:
  - If any req_valid_i is high, select the first valid index scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - Register its one-hot value into grant_o and go to LOCK. Arbitration costs 1 cycle.
  - If no requester is valid, stay in IDLE.
- FSM LOCK, with g = granted index:
  - req_ready_o[g] = !fifo_wr_full_i. All other ready bits are 0.
  - fifo_wr_en_o = req_valid_i[g] & !fifo_wr_full_i.
  - fifo_wr_data_o = req_data_i[g] while in LOCK; 0 in IDLE.
  - All three are combinational, so a beat transfers in the same cycle it is accepted.
- Release:
  - On a transfer with req_last_i[g]=1 (or any transfer when PACKET_MODE=0): rr_ptr <= (g+1) mod NUM_REQ, grant_o <= 0, go to IDLE.
  - This gives a fixed 1-cycle bubble between packets. Peak throughput is one beat per cycle inside a packet.
- Full mid-packet: stall, grant held, no write, data must be held by the requester.
- Valid low mid-packet: grant held, no write; other requesters stay blocked.
- Requester rules: hold data/last stable while valid & !ready; valid may rise without waiting for ready.
- Reset mid-packet: the packet is abandoned with no flush. After release, arbitration restarts from requester 0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- NUM_REQ=1: degenerates to a gated pass-through with the 1-cycle bubble.
- rr_ptr width is $clog2(NUM_REQ), minimum 1. Wrap is explicit modulo, not natural overflow.

Optional Feature:
- Macro: FIFO_WR_ARB_TIMEOUT_EN.
- Enabled:
  - In LOCK, a counter increments on cycles with req_valid_i[g]=0. Cycles stalled by full do not count. The counter clears on any transfer.
  - At TIMEOUT_CYCLES: grant is released, rr_ptr advances past g, the FSM goes to IDLE, and timeout_o pulses for 1 cycle.
  - The partial packet already written is not recalled.
- Disabled: no counter, no timeout_o port; the grant is held indefinitely.

Decomposition:
- Package fifo_wr_arb_pkg:
  - State enum {IDLE, LOCK}.
  - Function idx_width(n) returning max(1,$clog2(n)).
  - Function onehot2idx.
- Sub-module rr_pick (combinational):
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and a valid flag.
  - Implemented as a rotate, priority encode, rotate back.

Test Plan:
- Reset then idle: all valid=0 for 10 cycles -> grant_o=0, fifo_wr_en_o=0, all ready=0.
- Contention: requesters 0..3 each present a 2-beat packet simultaneously (data 0xk0, 0xk1) -> FIFO receives 00,01,10,11,20,21,30,31, with a 1-cycle bubble between packets.
- Full backpressure: fifo_wr_full_i=1 during beat 2 of requester 1's 3-beat packet for 5 cycles -> fifo_wr_en_o=0 and ready[1]=0 for those cycles, grant_o=0010 held, no data lost.
- Round-robin fairness: only requesters 2 and 0 valid, rr_ptr=1 -> 2 is granted first, then 0, then 2.
- Reset mid-packet: assert wr_reset_n=0 after beat 1 of 4 -> outputs 0 immediately (async); after release, requester 3 and requester 0 valid -> 0 granted.
- (FIFO_WR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): granted requester drops valid after beat 1 -> timeout_o pulses on the 8th idle cycle, grant_o=0 next cycle, and the next requester is granted.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Used by rr_pick and fifo_wr_arbiter.
package fifo_wr_arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // A one-bit pointer is still needed when there is a single requester.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [3:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals of fifo_wr_arbiter.
// master = requesters plus FIFO status; slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [DATA_WIDTH-1:0]         fifo_wr_data_o;
    logic                          fifo_wr_en_o;
    logic                          fifo_wr_full_i;
    logic [NUM_REQ-1:0]            grant_o;
    logic                          busy_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, fifo_wr_full_i,
        input  req_ready_o, fifo_wr_data_o, fifo_wr_en_o, grant_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, fifo_wr_full_i,
        output req_ready_o, fifo_wr_data_o, fifo_wr_en_o, grant_o, busy_o
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector by the
// pointer, take the lowest set bit, rotate the one-hot result back.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   sel_rot;
    logic [2*NUM_REQ-1:0] sel_dbl;
    logic                 found;

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        req_dbl = {req_i, req_i} >> ptr_i;
        req_rot = req_dbl[NUM_REQ-1:0];
        sel_rot = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_rot[i] && !found) begin
                sel_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        // Upper half of the doubled left shift is the rotate-left by ptr_i.
        sel_dbl = {sel_rot, sel_rot} << ptr_i;
        grant_o = sel_dbl[2*NUM_REQ-1:NUM_REQ];
        valid_o = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin owner of the async FIFO write port; never writes while full.
// Optional idle-stall release under macro FIFO_WR_ARB_TIMEOUT_EN (adds timeout_o).
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int PACKET_MODE    = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic wr_clk,
    input  logic wr_reset_n,
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    output logic timeout_o,
`endif
    fifo_wr_arbiter_if.slave bus
);

    localparam int PTR_W = idx_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]    pick_grant;
    logic                  pick_valid;
    logic [MAX_REQ-1:0]    grant_ext;
    int                    g_int;
    logic                  valid_g;
    logic                  last_g;
    logic                  release_grant;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i   (bus.req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        req_ready     = '0;
        wr_en         = 1'b0;
        wr_data       = '0;
        busy          = 1'b0;
        release_grant = 1'b0;
        grant_ext     = '0;
        grant_ext[NUM_REQ-1:0] = grant_q;
        g_int   = int'(onehot2idx(grant_ext));
        valid_g = |(bus.req_valid_i & grant_q);
        last_g  = (PACKET_MODE == 0) ? 1'b1 : |(bus.req_last_i & grant_q);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
        timeout   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                busy      = 1'b1;
                // The FIFO does not gate its own write enable, so full is masked here.
                req_ready = bus.fifo_wr_full_i ? '0 : grant_q;
                wr_en     = valid_g & ~bus.fifo_wr_full_i;
                wr_data   = bus.req_data_i[g_int*DATA_WIDTH +: DATA_WIDTH];
                release_grant = wr_en & last_g;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                // Only cycles with the owner's valid low count; full stalls hold the count.
                if (valid_g) begin
                    tmo_cnt_d = wr_en ? '0 : tmo_cnt_q;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout       = 1'b1;
                    release_grant = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
                if (release_grant) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = PTR_W'((g_int + 1) % NUM_REQ);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values computed before the edge, independent of block order.
    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) tmo_cnt_q <= '0;
        else             tmo_cnt_q <= tmo_cnt_d;
    end

    assign timeout_o = timeout;
`endif

    assign bus.req_ready_o    = req_ready;
    assign bus.fifo_wr_en_o   = wr_en;
    assign bus.fifo_wr_data_o = wr_data;
    assign bus.grant_o        = grant_q;
    assign bus.busy_o         = busy;

endmodule
